soc_system_heater_pwm_out: RTL and testbench

//  Avalon-MM slave that drives the heater output pins. It is the output-side companion to the heater status input PIO.
//  HPS firmware writes a per-channel duty, and the block generates a glitch-free PWM on out_port.
//  A watchdog forces every heater off if firmware stops refreshing. This is the hardware thermal-runaway backstop.

---
 rtl/soc_system_heater_pwm_out.sv | 155 +++++++++++++++
 tb/tb_soc_system_heater_pwm_out.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_heater_pwm_out.sv
// Heater output PIO: per-channel PWM with duty shadowing, plus a watchdog that
// forces every heater off when firmware stops kicking it.
module soc_system_heater_pwm_out #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned PRESCALE    = 100,
  parameter int unsigned WDOG_CYCLES = 50000000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      address,
  input  logic            chipselect,
  input  logic            write_n,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [N_CH-1:0] out_port
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((32'd1 << PWM_BITS) - 32'd2);
  localparam logic [31:0]         WDOG_LOAD = 32'(WDOG_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRIP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q [N_CH];
  logic [PWM_BITS-1:0] duty_d [N_CH];
  logic [PWM_BITS-1:0] act_q  [N_CH];
  logic [PWM_BITS-1:0] act_d  [N_CH];
  logic [31:0]         wdog_q, wdog_d;
  logic [N_CH-1:0]     out_q, out_d;
  logic [31:0]         rd_q, rd_d;

  logic                wr, wr_ctrl, wr_kick, tick, wrap;
  logic [PWM_BITS-1:0] duty1_rd;
  logic                unused_wdata;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == 2'd0);
  assign wr_kick = wr && (address == 2'd3);

  assign tick = (pre_q == PRE_LAST);
  assign wrap = tick && (pwm_q == PWM_LAST);

  assign duty1_rd     = (N_CH >= 2) ? duty_q[(N_CH > 1) ? 1 : 0] : '0;
  assign unused_wdata = ^writedata[31:PWM_BITS];

  // Free-running timebase; it keeps its phase across enable/disable.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    pwm_d = pwm_q;
    if (tick) pwm_d = wrap ? '0 : pwm_q + PWM_BITS'(1);
  end

  // Active duty follows the next-state duty so a write landing on the wrap
  // clock is picked up by the period that starts there.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty_d[i] = duty_q[i];
      if ((i < 2) && wr && (address == 2'(i + 1))) duty_d[i] = writedata[PWM_BITS-1:0];
      act_d[i] = wrap ? duty_d[i] : act_q[i];
      out_d[i] = (state_q == ST_RUN) && (pwm_q < act_q[i]);
    end
  end

  // Watchdog count sits at its reset value in IDLE until the first RUN, and is
  // reloaded whenever the block drops back to IDLE.
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl && writedata[0]) begin
          state_d = ST_RUN;
          wdog_d  = WDOG_LOAD;
        end
      end
      ST_RUN: begin
        if (wr_ctrl && !writedata[0]) begin
          state_d = ST_IDLE;
          wdog_d  = WDOG_LOAD;
        end else if (wr_kick) begin
          wdog_d = WDOG_LOAD;
        end else if (wdog_q <= 32'd1) begin
          state_d = ST_TRIP;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q - 32'd1;
        end
      end
      ST_TRIP: begin
        wdog_d = '0;
        if (wr_ctrl && writedata[1]) begin
          state_d = ST_IDLE;
          wdog_d  = WDOG_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wdog_d  = WDOG_LOAD;
      end
    endcase
  end

  always_comb begin
    rd_d = '0;
    case (address)
      2'd0: begin
        rd_d[0]         = (state_q == ST_RUN);
        rd_d[1]         = (state_q == ST_TRIP);
        rd_d[8 +: N_CH] = out_q;
      end
      2'd1:    rd_d[PWM_BITS-1:0] = duty_q[0];
      2'd2:    rd_d[PWM_BITS-1:0] = duty1_rd;
      default: rd_d = wdog_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      pwm_q   <= '0;
      wdog_q  <= '0;
      out_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      wdog_q  <= wdog_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
      for (int i = 0; i < N_CH; i++) begin
        duty_q[i] <= duty_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_soc_system_heater_pwm_out.sv
// Bench for soc_system_heater_pwm_out: register vectors, directed PWM and
// watchdog sequences, and random bus traffic against a timeline model.
module tb_soc_system_heater_pwm_out;

  localparam int PRE = 4;
  localparam int WD  = 1000;
  localparam int PER = PRE * 255;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_TRIP = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [1:0]  out_port;

  soc_system_heater_pwm_out #(
    .N_CH(2), .PWM_BITS(8), .PRESCALE(PRE), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: time is counted in clock edges since reset. PWM position and period
  // boundaries come from plain division; the watchdog is "edges since refresh".
  typedef struct {
    int          n;
    int          duty0, duty1, act0, act1;
    int          mode;
    int          last;
    int          idle_wd;
    logic [1:0]  out;
    logic [31:0] rd;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t model_reset();
    mdl_t t;
    t.n = 0; t.duty0 = 0; t.duty1 = 0; t.act0 = 0; t.act1 = 0;
    t.mode = M_IDLE; t.last = 0; t.idle_wd = 0; t.out = 2'b00; t.rd = 32'd0;
    return t;
  endfunction

  function automatic mdl_t model_step(input mdl_t s, input logic [1:0] a,
                                      input logic wr, input logic [31:0] d);
    mdl_t t;
    int   pos, wd;
    t   = s;
    pos = (s.n / PRE) % 255;
    t.out[0] = (s.mode == M_RUN) && (pos < s.act0);
    t.out[1] = (s.mode == M_RUN) && (pos < s.act1);
    wd = (s.mode == M_RUN) ? WD - (s.n - s.last) : (s.mode == M_TRIP) ? 0 : s.idle_wd;
    case (a)
      2'd0:    t.rd = {22'd0, s.out, 6'd0, s.mode == M_TRIP, s.mode == M_RUN};
      2'd1:    t.rd = 32'(s.duty0);
      2'd2:    t.rd = 32'(s.duty1);
      default: t.rd = 32'(wd);
    endcase
    if (wr) begin
      case (a)
        2'd0: begin
          if (s.mode == M_IDLE && d[0]) begin t.mode = M_RUN; t.last = s.n + 1; end
          else if (s.mode == M_RUN && !d[0]) begin t.mode = M_IDLE; t.idle_wd = WD; end
          else if (s.mode == M_TRIP && d[1]) begin t.mode = M_IDLE; t.idle_wd = WD; end
        end
        2'd1: t.duty0 = int'(d[7:0]);
        2'd2: t.duty1 = int'(d[7:0]);
        default: if (s.mode == M_RUN) t.last = s.n + 1;
      endcase
    end
    t.n = s.n + 1;
    if (t.mode == M_RUN && (t.n - t.last) >= WD) t.mode = M_TRIP;
    if (t.n % PER == 0) begin t.act0 = t.duty0; t.act1 = t.duty1; end
    return t;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mdl <= model_reset();
    else          mdl <= model_step(mdl, address, chipselect && !write_n, writedata);
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model_out_port", {30'd0, out_port}, {30'd0, mdl.out});
      check("model_readdata", readdata, mdl.rd);
    end
  end

  // Run-length monitor on channel 0.
  int   hi_q[$];
  int   lo_q[$];
  int   run_len = 0;
  int   hi_total = 0;
  logic prev0 = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      run_len <= 0;
      prev0   <= 1'b0;
    end else begin
      hi_total <= hi_total + int'(out_port[0]);
      if (out_port[0] == prev0) run_len <= run_len + 1;
      else begin
        if (prev0) hi_q.push_back(run_len);
        else       lo_q.push_back(run_len);
        run_len <= 1;
        prev0   <= out_port[0];
      end
    end
  end

  // Driver tasks: all are entered and left at a falling edge.
  bit auto_kick = 1'b0;
  int kick_ctr  = 0;

  task automatic step();
    if (auto_kick && kick_ctr >= 200) begin
      chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'd0;
      kick_ctr = 0;
    end else begin
      chipselect = 1'b0; write_n = 1'b1;
      kick_ctr++;
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    kick_ctr++;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b0; write_n = 1'b1; address = a;
    kick_ctr++;
    @(negedge clk);
    d = readdata;
  endtask

  typedef struct {
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] d;
    int          h0;
    bit          found;
    logic        last;

    vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'd0,     2'd0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'd0,     2'd1, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'd0,     2'd2, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'd0,     2'd3, 32'd0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'hAB,    2'd2, 32'hAB};
    vecs[5]  = '{1'b1, 1'b1, 2'd1, 32'h1FF,   2'd1, 32'hFF};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h55,    2'd1, 32'hFF};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h11,    2'd2, 32'hAB};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 32'h2,     2'd0, 32'd0};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 32'd0,     2'd1, 32'd0};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 32'd0,     2'd2, 32'd0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("reset_out_port", {30'd0, out_port}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      chipselect = vecs[i].cs; write_n = !vecs[i].wr;
      address = vecs[i].addr; writedata = vecs[i].data;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      bus_read(vecs[i].raddr, d);
      check($sformatf("vec%0d_read", i), d, vecs[i].exp);
    end

    // Duty 64 -> 256 clk high, 764 clk low.
    bus_write(2'd1, 32'd64);
    bus_write(2'd0, 32'd1);
    auto_kick = 1'b1;
    run(1100);
    hi_q.delete(); lo_q.delete();
    run(3 * PER + 50);
    check("duty64_high_len", (hi_q.size() > 0) ? 32'(hi_q[$]) : 32'hFFFF_FFFF, 32'd256);
    check("duty64_low_len",  (lo_q.size() > 0) ? 32'(lo_q[$]) : 32'hFFFF_FFFF, 32'd764);

    bus_write(2'd1, 32'd0);
    run(1100);
    h0 = hi_total;
    run(1100);
    check("duty0_high_cycles", 32'(hi_total - h0), 32'd0);

    bus_write(2'd1, 32'd255);
    run(1100);
    h0 = hi_total;
    run(1100);
    check("duty255_high_cycles", 32'(hi_total - h0), 32'd1100);

    // Mid-pulse duty change 128 -> 32.
    bus_write(2'd1, 32'd128);
    run(1100);
    found = 1'b0;
    last  = out_port[0];
    for (int k = 0; k < 2100 && !found; k++) begin
      step();
      if (out_port[0] && !last) found = 1'b1;
      last = out_port[0];
    end
    check("rise_seen", {31'd0, found}, 32'd1);
    hi_q.delete();
    run(200);
    bus_write(2'd1, 32'd32);
    run(2 * PER);
    check("midpulse_cur_len",  (hi_q.size() > 0) ? 32'(hi_q[0]) : 32'hFFFF_FFFF, 32'd512);
    check("midpulse_next_len", (hi_q.size() > 1) ? 32'(hi_q[1]) : 32'hFFFF_FFFF, 32'd128);

    // Watchdog trip with no kicks.
    bus_write(2'd1, 32'd255);
    run(1100);
    auto_kick = 1'b0;
    bus_write(2'd0, 32'd0);
    bus_write(2'd0, 32'd1);
    run(1000);
    check("wd_last_on", {31'd0, out_port[0]}, 32'd1);
    step();
    check("wd_trip_off", {30'd0, out_port}, 32'd0);
    bus_read(2'd0, d);
    check("wd_trip_ctrl", d, 32'h2);
    bus_write(2'd0, 32'd1);
    bus_read(2'd0, d);
    check("wd_enable_ignored", d, 32'h2);
    check("wd_still_off", {30'd0, out_port}, 32'd0);
    bus_write(2'd0, 32'd2);
    bus_read(2'd0, d);
    check("wd_cleared", d, 32'h0);
    bus_write(2'd0, 32'd1);
    run(3);
    bus_read(2'd0, d);
    check("wd_rearmed", d, 32'h101);

    // Kick landing in the expiry clock.
    bus_write(2'd0, 32'd0);
    bus_write(2'd0, 32'd1);
    run(999);
    bus_write(2'd3, 32'd0);
    bus_read(2'd3, d);
    check("kick_at_expiry_count", d, 32'(WD));
    bus_read(2'd0, d);
    check("kick_at_expiry_run", d, 32'h101);

    // Asynchronous reset mid-RUN.
    auto_kick = 1'b1;
    run(50);
    check("pre_reset_on", {31'd0, out_port[0]}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out", {30'd0, out_port}, 32'd0);
    check("async_reset_rd", readdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    kick_ctr = 0;
    bus_read(2'd1, d);
    check("post_reset_duty0", d, 32'd0);
    bus_read(2'd0, d);
    check("post_reset_ctrl", d, 32'd0);

    // Random traffic; every cycle is compared against the model.
    auto_kick = 1'b0;
    bus_write(2'd0, 32'd1);
    for (int i = 0; i < 6000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
          address = 2'($urandom_range(0, 3));
        end
        5, 6: begin
          chipselect = 1'b1; write_n = 1'b0;
          address = 2'($urandom_range(1, 2)); writedata = $urandom;
        end
        7: begin
          chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = $urandom;
        end
        8: begin
          chipselect = 1'b1; write_n = 1'b0; address = 2'd0;
          writedata = 32'($urandom_range(0, 3));
        end
        default: begin
          chipselect = 1'b0; write_n = 1'b0;
          address = 2'($urandom_range(0, 3)); writedata = $urandom;
        end
      endcase
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
